fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage.
- Owns the program counter and issues requests to the instruction memory over a req/ready handshake.
- Delivers instruction, pc_plus_4 and pc_page to the IF/ID pipeline register, and drives that register's write-enable and flush.
- Accepts stalls from the hazard unit and branch/jump redirects resolved in ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width (word-aligned, bits [1:0] always 0)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  hazard unit: hold PC, do not hand over a new instruction
branch_taken_i  in  1  ID: branch resolved taken
branch_target_i  in  32  ID: branch target address
jump_i  in  1  ID: unconditional jump
jump_index_i  in  26  ID: instruction[25:0] of the jump
jump_page_i  in  4  ID: pc_page of the jump instruction
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address
imem_ready_i  in  1  memory: imem_rdata_i valid this cycle
imem_rdata_i  in  32  memory read data
instruction_o  out  32  to IF/ID instruction_in
pc_plus_4_o  out  32  to IF/ID pc_plus_4_in
pc_page_o  out  4  to IF/ID pc_page_in
if_id_write_o  out  1  to IF/ID IF_ID_write
flush_o  out  1  to IF/ID flush

Behaviour:
- State register, 3 states:
  - S_REQ: request outstanding.
  - S_HOLD: fetched word buffered, waiting out a stall.
  - S_DRAIN: discarding a stale in-flight word after a redirect.
- Reset:
  - pc=RESET_PC, state=S_REQ, hold buffer=0, redirect pending=0.
  - All outputs 0 while rst is high.
  - Reset mid-fetch abandons the request; the memory is reset on the same rst.
- Memory handshake:
  - imem_req_o=1 in S_REQ and S_DRAIN.
  - imem_addr_o is held stable until imem_ready_i.
  - Read data is consumed combinationally in the cycle imem_ready_i=1.
  - Zero or more wait cycles are allowed.
- Derived values:
  - pc_plus_4_o = pc+4, modulo 2^32; wrap from 32'hFFFF_FFFC gives 0.
  - pc_page_o = pc_plus_4_o[31:28].
  - Branch target = branch_target_i.
  - Jump target = {jump_page_i, jump_index_i, 2'b00}.
- Redirect:
  - redirect = branch_taken_i | jump_i. jump_i wins if both are asserted; simulation assertion flags that case.
  - Redirect has priority over stall and over any fetch result.
  - Same cycle: flush_o=1, if_id_write_o=1 (IF/ID loads zeros), pc <= target.
  - If in S_REQ without ready, go to S_DRAIN. Otherwise go to S_REQ.
  - A word returned in the redirect cycle is discarded.
  - From S_HOLD, the buffer is dropped and the next state is S_REQ.
- S_REQ, ready=1, no stall:
  - instruction_o=imem_rdata_i, if_id_write_o=1, pc <= pc+4, stay in S_REQ.
  - Back-to-back fetches give 1 instruction/cycle when ready is always high.
- S_REQ, ready=1, stall=1: capture rdata into the hold buffer, go to S_HOLD, if_id_write_o=0.
- S_REQ, ready=0: if_id_write_o=0. A stall alone changes nothing.
- S_HOLD:
  - imem_req_o=0, if_id_write_o=0 while stalled.
  - On !stall: instruction_o=buffer, if_id_write_o=1, pc <= pc+4, go to S_REQ.
- S_DRAIN:
  - Address = old PC is held; IF/ID outputs inactive.
  - On ready: data discarded, go to S_REQ at the new pc.
  - A further redirect during S_DRAIN updates pc and stays in S_DRAIN.
- Outputs when no handover: instruction_o, pc_plus_4_o and pc_page_o are don't-care, but driven deterministically (pc-based values, instruction 0).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched_o[31:0] (increments on each non-flushed handover).
  - Adds perf_stall_o[31:0] (increments each cycle in S_HOLD or in S_REQ without ready).
  - Adds perf_flush_o[31:0] (increments per redirect).
  - All counters are reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants header, extending the existing one:
  - WORD_ZERO
  - fetch state encodings FETCH_S_REQ/FETCH_S_HOLD/FETCH_S_DRAIN
  - PC_INCR (4)
- One natural sub-module, fetch_next_pc: a combinational next-PC mux (pc+4 / branch / jump target plus page concatenation).

Test Plan:
- Reset RESET_PC=0, ready always 1, no stall: imem_addr_o is 0,4,8 on consecutive cycles; if_id_write_o=1 every cycle; pc_plus_4_o=4,8,12; pc_page_o=0.
- Ready delayed 3 cycles at pc=0x10: imem_addr_o holds 0x10 for 4 cycles; a single handover carries rdata with pc_plus_4_o=0x14.
- Stall asserted in the ready cycle at pc=0x20, data 0xAABBCCDD, 2 cycles: imem_req_o=0 while held; on release, instruction_o=0xAABBCCDD and if_id_write_o=1; the next address is 0x24.
- Jump with jump_page_i=4'hA, index 26'h0000010 while a fetch is in flight: flush_o=1 and if_id_write_o=1 in that cycle; the stale word is discarded; the next issued address is 0xA000_0040.
- Branch taken to 0x100 simultaneous with stall and ready: flush wins, the returned data is dropped, and the next address is 0x100.
- pc=32'hFFFF_FFFC fetch: pc_plus_4_o=0, pc_page_o=0, and the next address is 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: zero word, fetch FSM encodings and PC increment.
package fetch_unit_pkg;
  localparam logic [31:0] WORD_ZERO     = 32'h0000_0000;
  localparam logic [1:0]  FETCH_S_REQ   = 2'd0;
  localparam logic [1:0]  FETCH_S_HOLD  = 2'd1;
  localparam logic [1:0]  FETCH_S_DRAIN = 2'd2;
  localparam logic [31:0] PC_INCR       = 32'd4;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ready bus; master is the fetch stage, slave is the memory.
interface fetch_unit_if #(parameter int ADDR_W = 32);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC sources: sequential pc+4 and the redirect target (jump beats branch).
module fetch_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic [3:0]        jump_page_i,
  output logic [ADDR_W-1:0] pc_plus_4,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_target
);
  logic [ADDR_W-1:0] jump_target;

  assign pc_plus_4       = pc + PC_INCR[ADDR_W-1:0];
  assign jump_target     = {jump_page_i, jump_index_i, 2'b00};
  assign redirect        = branch_taken_i | jump_i;
  assign redirect_target = jump_i ? jump_target : branch_target_i;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to imem over req/ready, feeds IF/ID.
// Optional perf counters (fetched/stall/flush) enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic [3:0]        jump_page_i,
  fetch_unit_if.master      imem,
  output logic [31:0]       instruction_o,
  output logic [ADDR_W-1:0] pc_plus_4_o,
  output logic [3:0]        pc_page_o,
  output logic              if_id_write_o,
  output logic              flush_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_flush_o
`endif
);
  logic [1:0]        state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, drain_addr, pc_plus_4, redirect_target;
  logic [31:0]       hold_buf;
  logic              redirect, handover, capture;

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc              (pc),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .jump_page_i     (jump_page_i),
    .pc_plus_4       (pc_plus_4),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  assign handover = !rst && !redirect && !stall_i &&
                    ((state == FETCH_S_REQ && imem.ready) || state == FETCH_S_HOLD);
  assign capture  = !redirect && stall_i && state == FETCH_S_REQ && imem.ready;

  always_comb begin
    state_d = state;
    pc_d    = pc;
    if (redirect) begin
      pc_d = redirect_target;
      // An unanswered request is still owed a response; swallow it in DRAIN.
      state_d = (state != FETCH_S_HOLD && !imem.ready) ? FETCH_S_DRAIN : FETCH_S_REQ;
    end else begin
      case (state)
        FETCH_S_REQ:   if (imem.ready) begin
                         if (stall_i) state_d = FETCH_S_HOLD;
                         else         pc_d    = pc_plus_4;
                       end
        FETCH_S_HOLD:  if (!stall_i) begin
                         state_d = FETCH_S_REQ;
                         pc_d    = pc_plus_4;
                       end
        FETCH_S_DRAIN: if (imem.ready) state_d = FETCH_S_REQ;
        default:       state_d = FETCH_S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH_S_REQ;
      pc         <= RESET_PC[ADDR_W-1:0];
      drain_addr <= RESET_PC[ADDR_W-1:0];
      hold_buf   <= WORD_ZERO;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      // Tracks the issued address so DRAIN keeps presenting the old request.
      if (state == FETCH_S_REQ) drain_addr <= pc;
      if (capture)              hold_buf   <= imem.rdata;
    end
  end

  assign imem.req      = !rst && (state == FETCH_S_REQ || state == FETCH_S_DRAIN);
  assign imem.addr     = rst ? '0 : (state == FETCH_S_DRAIN ? drain_addr : pc);
  assign flush_o       = !rst && redirect;
  assign if_id_write_o = flush_o || handover;
  assign instruction_o = !handover ? WORD_ZERO :
                         (state == FETCH_S_HOLD ? hold_buf : imem.rdata);
  assign pc_plus_4_o   = rst ? '0 : pc_plus_4;
  assign pc_page_o     = pc_plus_4_o[ADDR_W-1 -: 4];

  a_jump_branch_excl: assert property (@(posedge clk) disable iff (rst) !(jump_i && branch_taken_i));

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
      perf_flush_o   <= '0;
    end else begin
      if (handover) perf_fetched_o <= perf_fetched_o + 32'd1;
      if (state == FETCH_S_HOLD || (state == FETCH_S_REQ && !imem.ready))
        perf_stall_o <= perf_stall_o + 32'd1;
      if (redirect) perf_flush_o <= perf_flush_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench acts as imem, scoreboard holds expected handovers.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_taken_i, jump_i;
  logic [31:0] branch_target_i;
  logic [25:0] jump_index_i;
  logic [3:0]  jump_page_i;
  logic [31:0] instruction_o, pc_plus_4_o;
  logic [3:0]  pc_page_o;
  logic        if_id_write_o, flush_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o, perf_stall_o, perf_flush_o;
`endif

  fetch_unit_if #(.ADDR_W(32)) imem ();

  fetch_unit #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .jump_page_i     (jump_page_i),
    .imem            (imem),
    .instruction_o   (instruction_o),
    .pc_plus_4_o     (pc_plus_4_o),
    .pc_page_o       (pc_page_o),
    .if_id_write_o   (if_id_write_o),
    .flush_o         (flush_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o  (perf_fetched_o),
    .perf_stall_o    (perf_stall_o),
    .perf_flush_o    (perf_flush_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pp4;
    logic [3:0]  page;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_err = 0, n_push = 0, n_hand = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pp4, input logic [3:0] page);
    exp_t e;
    e.ins = ins; e.pp4 = pp4; e.page = page;
    q.push_back(e);
    n_push++;
  endtask

  task automatic mem(input logic r, input logic [31:0] d);
    imem.ready = r;
    imem.rdata = d;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Handover monitor: every non-flush IF/ID write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && if_id_write_o && !flush_o) begin
      n_hand++;
      if (q.size() == 0) chk("unexpected_handover", instruction_o, 32'hFFFF_FFFF ^ instruction_o);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_instr", instruction_o, e.ins);
        chk("sb_pc_plus_4", pc_plus_4_o, e.pp4);
        chk("sb_page", {28'h0, pc_page_o}, {28'h0, e.page});
      end
    end
  end

  initial begin
    rst = 1'b1; stall_i = 0; branch_taken_i = 0; jump_i = 0;
    branch_target_i = 0; jump_index_i = 0; jump_page_i = 0;
    mem(1'b1, 32'h1234_5678);
    @(negedge clk);
    chk("rst_req", {31'h0, imem.req}, 32'h0);
    chk("rst_addr", imem.addr, 32'h0);
    chk("rst_write", {31'h0, if_id_write_o}, 32'h0);
    chk("rst_flush", {31'h0, flush_o}, 32'h0);
    chk("rst_pp4", pc_plus_4_o, 32'h0);
    chk("rst_instr", instruction_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming fetch, one word per cycle: pcs 0,4,8,c.
    for (int k = 0; k < 4; k++) begin
      mem(1'b1, 32'h1000_0000 | (k * 4));
      push(32'h1000_0000 | (k * 4), (k + 1) * 4, 4'h0);
      @(negedge clk);
      chk("seq_addr", imem.addr, k * 4);
      chk("seq_write", {31'h0, if_id_write_o}, 32'h1);
      adv();
    end

    // Three wait cycles at 0x10, then data.
    for (int k = 0; k < 3; k++) begin
      mem(1'b0, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("wait_addr", imem.addr, 32'h10);
      chk("wait_req", {31'h0, imem.req}, 32'h1);
      chk("wait_write", {31'h0, if_id_write_o}, 32'h0);
      adv();
    end
    mem(1'b1, 32'hDEAD_0010);
    push(32'hDEAD_0010, 32'h14, 4'h0);
    @(negedge clk);
    chk("wait_addr_rdy", imem.addr, 32'h10);
    adv();

    // Walk to 0x20, then stall in the ready cycle.
    for (int k = 0; k < 3; k++) begin
      mem(1'b1, 32'h2000_0014 + k * 4);
      push(32'h2000_0014 + k * 4, 32'h18 + k * 4, 4'h0);
      adv();
    end
    stall_i = 1'b1;
    mem(1'b1, 32'hAABB_CCDD);
    @(negedge clk);
    chk("stall_cap_addr", imem.addr, 32'h20);
    chk("stall_cap_write", {31'h0, if_id_write_o}, 32'h0);
    adv();
    for (int k = 0; k < 2; k++) begin
      mem(1'b0, 32'h0);
      @(negedge clk);
      chk("hold_req", {31'h0, imem.req}, 32'h0);
      chk("hold_write", {31'h0, if_id_write_o}, 32'h0);
      adv();
    end
    stall_i = 1'b0;
    push(32'hAABB_CCDD, 32'h24, 4'h0);
    @(negedge clk);
    chk("release_write", {31'h0, if_id_write_o}, 32'h1);
    adv();
    @(negedge clk);
    chk("after_hold_addr", imem.addr, 32'h24);
    chk("after_hold_req", {31'h0, imem.req}, 32'h1);
    adv();

    // Jump while the 0x24 fetch is still outstanding.
    jump_i = 1'b1; jump_page_i = 4'hA; jump_index_i = 26'h000_0010;
    @(negedge clk);
    chk("jmp_flush", {31'h0, flush_o}, 32'h1);
    chk("jmp_write", {31'h0, if_id_write_o}, 32'h1);
    chk("jmp_instr", instruction_o, 32'h0);
    adv();
    jump_i = 1'b0;
    @(negedge clk);
    chk("drain_addr", imem.addr, 32'h24);
    chk("drain_write", {31'h0, if_id_write_o}, 32'h0);
    adv();
    mem(1'b1, 32'h0BAD_0BAD);
    @(negedge clk);
    chk("drain_drop_write", {31'h0, if_id_write_o}, 32'h0);
    adv();
    mem(1'b0, 32'h0);
    @(negedge clk);
    chk("jmp_target_addr", imem.addr, 32'hA000_0040);
    adv();
    mem(1'b1, 32'h3000_0001);
    push(32'h3000_0001, 32'hA000_0044, 4'hA);
    adv();

    // Branch coinciding with stall and ready: the redirect wins.
    branch_taken_i = 1'b1; branch_target_i = 32'h100; stall_i = 1'b1;
    mem(1'b1, 32'h0BAD_BAD0);
    @(negedge clk);
    chk("br_flush", {31'h0, flush_o}, 32'h1);
    chk("br_instr", instruction_o, 32'h0);
    adv();
    branch_taken_i = 1'b0; stall_i = 1'b0;
    mem(1'b0, 32'h0);
    @(negedge clk);
    chk("br_target_addr", imem.addr, 32'h100);
    adv();
    mem(1'b1, 32'h4000_0100);
    push(32'h4000_0100, 32'h104, 4'h0);
    adv();

    // PC wrap at the top of the address space.
    branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    mem(1'b1, 32'h0BAD_0000);
    adv();
    branch_taken_i = 1'b0;
    mem(1'b1, 32'h5000_FFFC);
    push(32'h5000_FFFC, 32'h0, 4'h0);
    @(negedge clk);
    chk("wrap_addr", imem.addr, 32'hFFFF_FFFC);
    adv();
    mem(1'b0, 32'h0);
    @(negedge clk);
    chk("wrap_next_addr", imem.addr, 32'h0);
    adv();

    // Second redirect while draining: the newest target wins, old address stays on the bus.
    jump_i = 1'b1; jump_page_i = 4'h0; jump_index_i = 26'h000_0040;
    adv();
    jump_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h200;
    @(negedge clk);
    chk("drain_redir_flush", {31'h0, flush_o}, 32'h1);
    chk("drain_redir_addr", imem.addr, 32'h0);
    adv();
    branch_taken_i = 1'b0;
    @(negedge clk);
    chk("drain2_addr", imem.addr, 32'h0);
    adv();
    mem(1'b1, 32'h0BAD_1111);
    @(negedge clk);
    chk("drain2_drop_write", {31'h0, if_id_write_o}, 32'h0);
    adv();
    mem(1'b0, 32'h0);
    @(negedge clk);
    chk("drain2_target_addr", imem.addr, 32'h200);
    adv();

    chk("sb_empty", q.size(), 32'h0);
    chk("handover_count", n_hand, n_push);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched_o, n_push);
    chk("perf_flush", perf_flush_o, 32'd5);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got %0d exp 0", n_chk);
    $fatal(1, "timeout");
  end
endmodule
